program_loader: RTL and testbench

- Writer side of the 16 x 8-bit instruction memory: receives a program as a byte stream over a valid/ready handshake, clears memory to NOP, writes each instruction byte to consecutive addresses, and checks a length/checksum framing.
- Sits between a host byte source (UART receiver or testbench) and the write port of the instruction store.
- Holds the CPU in reset-hold until a complete, checksum-correct program is resident.

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader_if.sv | 27 ++
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the instruction-store loader.
package program_loader_pkg;

    localparam int IMEM_ADDR_W = 4;
    localparam int IMEM_DATA_W = 8;
    localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;
    localparam logic [7:0] NOP_WORD = 8'hF0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    // A program length is legal when it is non-zero and fits the store.
    function automatic logic len_ok(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (int'(n) <= depth);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream in, instruction-memory write port and CPU control out.
interface program_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, error, count
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, error, count
    );
endinterface

// File: rtl/program_loader.sv
// Loads a LEN/data/CSUM framed program into the instruction store after clearing it to NOP.
// Latency: each accepted data byte is written one cycle later; all outputs registered.
// Backpressure: in_ready low outside LEN/DATA/CSUM, so the source holds its byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_W   = IMEM_ADDR_W,
    parameter int         DATA_W   = IMEM_DATA_W,
    parameter logic [7:0] NOP_FILL = NOP_WORD
) (
    input logic            clk,
    input logic            rst,
    program_loader_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic              xfer;

    assign xfer = bus.in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        mem_we_d   = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;
        count_d    = count_q;
        len_d      = len_q;
        csum_d     = csum_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (bus.start) begin
                    state_d    = CLEAR;
                    in_ready_d = 1'b0;
                    mem_we_d   = 1'b1;
                    waddr_d    = '0;
                    wdata_d    = NOP_FILL[DATA_W-1:0];
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    count_d    = '0;
                    len_d      = '0;
                    csum_d     = '0;
                end
            end
            CLEAR: begin
                if (waddr_q == ADDR_TOP) begin
                    state_d    = LEN;
                    in_ready_d = 1'b1;
                end else begin
                    mem_we_d = 1'b1;
                    waddr_d  = waddr_q + ADDR_ONE;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (len_ok(bus.in_data[7:0], DEPTH)) begin
                        state_d = DATA;
                        len_d   = bus.in_data[ADDR_W:0];
                    end else begin
                        state_d    = ERROR;
                        in_ready_d = 1'b0;
                        error_d    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    mem_we_d = 1'b1;
                    waddr_d  = count_q[ADDR_W-1:0];
                    wdata_d  = bus.in_data;
                    csum_d   = csum_q + bus.in_data[7:0];
                    count_d  = count_q + CNT_ONE;
                    if (count_q + CNT_ONE == len_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    in_ready_d = 1'b0;
                    if (bus.in_data[7:0] == csum_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                cpu_hold_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            len_q      <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            count_q    <= count_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: expected memory writes are queued as bytes are sent and popped as writes appear.
module tb_program_loader;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    wr_t        exp_q[$];
    logic [7:0] exp_mem[16];
    logic [7:0] dut_mem[16];
    logic [7:0] stim[$];

    program_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    program_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got addr=%0h data=%0h, expected none",
                         bus.mem_waddr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_waddr, bus.mem_wdata} !== {e.a, e.d}) begin
                    bad++;
                    $display("FAIL write got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             bus.mem_waddr, bus.mem_wdata, e.a, e.d);
                end
            end
            dut_mem[bus.mem_waddr] = bus.mem_wdata;
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic begin_load();
        wr_t w;
        int  waited;
        for (int a = 0; a < 16; a++) begin
            w.a = 4'(a);
            w.d = 8'hF0;
            exp_q.push_back(w);
            exp_mem[a] = 8'hF0;
        end
        pulse_start();
        waited = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_timeout in_ready=%b, expected 1 within 40 cycles", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input bit toggle, input int start_at);
        wr_t w;
        int  n;
        int  waited;
        bit  ok;
        n  = int'(stim[0]);
        ok = (n >= 1) && (n <= 16);
        for (int i = 0; i < stim.size(); i++) begin
            bus.in_data  = stim[i];
            bus.in_valid = 1'b1;
            if (i == start_at) bus.start = 1'b1;
            waited = 0;
            @(negedge clk);
            while (bus.in_ready !== 1'b1 && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (bus.in_ready !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL stream_timeout byte=%0d in_ready=%b, expected 1", i, bus.in_ready);
                bus.in_valid = 1'b0;
                bus.start    = 1'b0;
                return;
            end
            @(posedge clk);
            if (ok && i >= 1 && i <= n) begin
                w.a = 4'(i - 1);
                w.d = stim[i];
                exp_q.push_back(w);
                exp_mem[i-1] = stim[i];
            end
            #1;
            bus.start = 1'b0;
            if (toggle) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && bus.error !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (bus.done !== 1'b1 && bus.error !== 1'b1) begin
            bad++;
            $display("FAIL end_timeout done=%b error=%b, expected one of them high", bus.done, bus.error);
        end
        @(negedge clk);
    endtask

    task automatic do_load(input bit toggle, input int start_at);
        begin_load();
        send_stream(toggle, start_at);
        wait_end();
    endtask

    task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                                input logic exp_hold, input logic [4:0] exp_cnt);
        total++;
        if ({bus.done, bus.error, bus.cpu_hold, bus.count} !== {exp_done, exp_err, exp_hold, exp_cnt}) begin
            bad++;
            $display("FAIL %s got done=%b error=%b hold=%b count=%0d, expected done=%b error=%b hold=%b count=%0d",
                     name, bus.done, bus.error, bus.cpu_hold, bus.count, exp_done, exp_err, exp_hold, exp_cnt);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got %0d writes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_mem(input string name);
        for (int a = 0; a < 16; a++) begin
            total++;
            if (dut_mem[a] !== exp_mem[a]) begin
                bad++;
                $display("FAIL %s_mem[%0d] got %0h, expected %0h", name, a, dut_mem[a], exp_mem[a]);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if ({bus.in_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.cpu_hold,
             bus.done, bus.error, bus.count} !== {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            bad++;
            $display("FAIL %s got rdy=%b we=%b addr=%0h data=%0h hold=%b done=%b err=%b cnt=%0d, expected 0 0 0 00 1 0 0 0",
                     name, bus.in_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.cpu_hold,
                     bus.done, bus.error, bus.count);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_clear();
        begin_load();
        check_status("clear", 1'b0, 1'b0, 1'b1, 5'd0);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_ready got %b, expected 1", bus.in_ready);
        end
        check_mem("clear");
        stim = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16};
        send_stream(1'b0, -1);
        wait_end();
        check_status("basic", 1'b1, 1'b0, 1'b0, 5'd3);
        check_mem("basic");
    endtask

    task automatic test_bad_csum();
        stim = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h17};
        do_load(1'b0, -1);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1, 5'd3);
        stim = '{8'h02, 8'h10, 8'h20, 8'h30};
        do_load(1'b0, -1);
        check_status("recover", 1'b1, 1'b0, 1'b0, 5'd2);
        check_mem("recover");
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[2];
        lens[0] = 8'h00;
        lens[1] = 8'h11;
        for (int k = 0; k < 2; k++) begin
            stim = '{lens[k]};
            do_load(1'b0, -1);
            check_status($sformatf("bad_len_%0h", lens[k]), 1'b0, 1'b1, 1'b1, 5'd0);
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bad_len_ready got %b, expected 0", bus.in_ready);
            end
        end
        check_mem("bad_len");
    endtask

    task automatic test_full(input bit toggle);
        stim = '{8'h10};
        for (int i = 0; i < 16; i++) stim.push_back(8'(i));
        stim.push_back(8'h78);
        do_load(toggle, -1);
        check_status(toggle ? "full_toggle" : "full", 1'b1, 1'b0, 1'b0, 5'd16);
        check_mem(toggle ? "full_toggle" : "full");
    endtask

    task automatic test_rst_mid();
        begin_load();
        stim = '{8'h05, 8'h11, 8'h22};
        send_stream(1'b0, -1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        check_status("rst_mid_status", 1'b0, 1'b0, 1'b1, 5'd0);
        check_mem("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_start_ignored();
        stim = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0F};
        do_load(1'b0, 2);
        check_status("start_ignored", 1'b1, 1'b0, 1'b0, 5'd5);
        check_mem("start_ignored");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_clear();
        test_bad_csum();
        test_bad_len();
        test_full(1'b0);
        test_full(1'b1);
        test_rst_mid();
        test_back_to_back_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
